spi_ram_bridge: RTL and testbench
=================================

Name: spi_ram_bridge

Overview:
- SPI mode-0 slave that acts as the initiator (CPU side) of the single-port RAM port, so an external host can load and read back program/data memory over SPI.
- Oversamples SCLK, CS_n and MOSI in the clk domain.
- Decodes a command/address header, then streams words to or from the RAM with address auto-increment.
- Sits between the board SPI pins and the memory's port, muxed against the CPU core by the integration level.

Parameters:
ADDR_WIDTH, 8, RAM word-address width; must be ≤ 8 (one address byte)
DATA_WIDTH, 32, RAM word width; must be a multiple of 8

Ports:
clk  input  1  system clock; the only clock
rst  input  1  asynchronous, active-high reset
spi_sclk  input  1  SPI clock from host, asynchronous to clk
spi_cs_n  input  1  chip select, active low, asynchronous
spi_mosi  input  1  host-to-slave data
spi_miso  output  1  slave-to-host data
spi_miso_oe  output  1  MISO output enable for the pad (= frame active)
mem_en  output  1  RAM port enable
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_WIDTH  RAM word address
mem_wdata  output  DATA_WIDTH  RAM write data
mem_rdata  input  DATA_WIDTH  RAM read data; synchronous RAM, valid the cycle after mem_en=1, we=0
busy  output  1  high while a frame is in progress

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, address counter 0.
- Input synchronisation:
  - spi_sclk, spi_cs_n and spi_mosi each pass through a 2-FF synchroniser.
  - Edge detection is done on the synchronised SCLK.
  - Requirement: f_clk ≥ 8 × f_SCLK.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first:
  - MOSI is sampled on detected SCLK rising edges.
  - MISO shift register advances on detected falling edges.
  - spi_miso = shift-register MSB while a read frame is active; 0 otherwise.
- Frame protocol (a frame is a CS_n-low interval):
  - Byte 0 is the command: 0x02 = WRITE, 0x03 = READ, anything else = IGNORE.
  - Byte 1 is the start address; its low ADDR_WIDTH bits are used.
  - Data phase follows: words of DATA_WIDTH/8 bytes, MSB byte first.
- States: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - IDLE → CMD on synchronised CS_n falling.
  - CMD → ADDR after 8 bits.
  - ADDR → WDATA or RDATA per command; CMD → IGNORE for an unknown command.
  - Any state → IDLE when synchronised CS_n is high, same cycle.
- WRITE:
  - Each complete word produces exactly one cycle of mem_en=1, mem_we=1, with mem_addr=current address and mem_wdata=assembled word.
  - This cycle starts the clk cycle after the word's last rising edge is detected.
  - Address then increments modulo 2^ADDR_WIDTH (0xFF → 0x00 wraps).
- READ:
  - On the rising edge that completes the address byte, issue mem_en=1, mem_we=0 for one cycle.
  - Capture mem_rdata into the prefetch buffer the following cycle, then load it into the shift register immediately, so the MSB is on MISO before the next SCLK rising edge.
  - On the last rising edge of each data word, prefetch address+1 into the buffer.
  - On the following falling edge, the shift register loads from the buffer.
  - The address wraps as for WRITE.
  - mem_we is never asserted in a READ frame.
- IGNORE: no mem_en; MISO stays 0 until CS_n goes high.
- CS_n high mid-word: the partial word is discarded and no RAM access is issued. A RAM access already issued completes its single cycle.
- busy and spi_miso_oe are 1 from CMD entry until return to IDLE.
- MOSI data during a READ data phase is ignored.
- rst asserted mid-frame: immediate return to reset values. The next frame after rst release and a fresh CS_n falling edge decodes normally.
- mem_en is never high for more than one consecutive cycle per word.

Test Plan:
- Single write (DATA_WIDTH=32, ADDR_WIDTH=8): CS low, bytes 02 10 DE AD BE EF, CS high → exactly one cycle mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; no other mem_en.
- Burst write with wrap: 02 FF 11111111 22222222 → writes 0x11111111 @0xFF then 0x22222222 @0x00.
- Burst read: RAM model holds 0x12345678 @0x20 and 0xCAFEF00D @0x21; host sends 03 20 followed by 8 dummy bytes → host samples 12 34 56 78 CA FE F0 0D; mem_we stays 0 throughout.
- Aborted write: 02 05 AA BB CC, CS high → no mem_we pulse; busy=0 within 3 clk of CS high.
- Unknown command: A5 00 FF FF FF FF → mem_en never asserted; spi_miso=0 for the whole frame.
- Reset mid-frame: assert rst during the data phase of a write → all outputs 0 immediately, no write issued; the following frame 02 01 00000001 writes 0x00000001 @0x01.

Source files
------------

// File: rtl/spi_ram_bridge.sv
// SPI mode-0 slave that drives a single-port synchronous RAM so a host can load
// and read back memory: command byte, address byte, then auto-incrementing words.
module spi_ram_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

  logic [2:0] pin_raw;
  logic [2:0] pin_sync;
  assign pin_raw = {spi_mosi, spi_cs_n, spi_sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= pin_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign pin_sync[gi] = sync_reg;
    end
  endgenerate

  logic sclk_s, cs_s, mosi_s;
  assign sclk_s = pin_sync[0];
  assign cs_s   = pin_sync[1];
  assign mosi_s = pin_sync[2];

  state_t                state_reg;
  logic                  sclk_d_reg, cs_d_reg, is_read_reg, busy_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [DATA_WIDTH-1:0] word_reg, shift_reg, buf_reg;
  logic [ADDR_WIDTH-1:0] addr_reg, mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic                  mem_en_reg, mem_we_reg;
  logic                  load_pend_reg, first_load_reg;
  logic [1:0]            rd_pipe_reg;

  logic                  rise, fall, cs_fall;
  logic [7:0]            new_byte;
  logic [DATA_WIDTH-1:0] new_word;
  assign rise     = sclk_s & ~sclk_d_reg;
  assign fall     = ~sclk_s & sclk_d_reg;
  assign cs_fall  = ~cs_s & cs_d_reg;
  assign new_byte = {word_reg[6:0], mosi_s};
  assign new_word = {word_reg[DATA_WIDTH-2:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      sclk_d_reg     <= 1'b0;
      cs_d_reg       <= 1'b0;
      is_read_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      bit_cnt_reg    <= '0;
      word_reg       <= '0;
      shift_reg      <= '0;
      buf_reg        <= '0;
      addr_reg       <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      load_pend_reg  <= 1'b0;
      first_load_reg <= 1'b0;
      rd_pipe_reg    <= '0;
    end else begin
      sclk_d_reg  <= sclk_s;
      cs_d_reg    <= cs_s;
      mem_en_reg  <= 1'b0;
      mem_we_reg  <= 1'b0;
      rd_pipe_reg <= {rd_pipe_reg[0], 1'b0};
      // rd_pipe[1] marks the cycle in which the synchronous RAM presents data
      if (rd_pipe_reg[1] && state_reg == RDATA && !cs_s) begin
        buf_reg <= mem_rdata;
        if (first_load_reg) begin
          shift_reg      <= mem_rdata;
          first_load_reg <= 1'b0;
        end
      end
      if (cs_s) begin
        state_reg      <= IDLE;
        busy_reg       <= 1'b0;
        bit_cnt_reg    <= '0;
        shift_reg      <= '0;
        load_pend_reg  <= 1'b0;
        first_load_reg <= 1'b0;
        rd_pipe_reg    <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (cs_fall) begin
              state_reg   <= CMD;
              busy_reg    <= 1'b1;
              bit_cnt_reg <= '0;
            end
          end
          CMD: begin
            if (rise) begin
              word_reg    <= new_word;
              bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
              if (bit_cnt_reg == BYTE_LAST) begin
                bit_cnt_reg <= '0;
                is_read_reg <= (new_byte == 8'h03);
                if (new_byte == 8'h02 || new_byte == 8'h03) state_reg <= ADDR;
                else state_reg <= IGNORE;
              end
            end
          end
          ADDR: begin
            if (rise) begin
              word_reg    <= new_word;
              bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
              if (bit_cnt_reg == BYTE_LAST) begin
                bit_cnt_reg <= '0;
                addr_reg    <= new_byte[ADDR_WIDTH-1:0];
                if (is_read_reg) begin
                  state_reg      <= RDATA;
                  mem_en_reg     <= 1'b1;
                  mem_addr_reg   <= new_byte[ADDR_WIDTH-1:0];
                  rd_pipe_reg    <= 2'b01;
                  first_load_reg <= 1'b1;
                end else begin
                  state_reg <= WDATA;
                end
              end
            end
          end
          WDATA: begin
            if (rise) begin
              word_reg    <= new_word;
              bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
              if (bit_cnt_reg == WORD_LAST) begin
                bit_cnt_reg   <= '0;
                mem_en_reg    <= 1'b1;
                mem_we_reg    <= 1'b1;
                mem_addr_reg  <= addr_reg;
                mem_wdata_reg <= new_word;
                addr_reg      <= addr_reg + ADDR_ONE;
              end
            end
          end
          RDATA: begin
            if (rise) begin
              bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
              if (bit_cnt_reg == WORD_LAST) begin
                bit_cnt_reg   <= '0;
                addr_reg      <= addr_reg + ADDR_ONE;
                mem_en_reg    <= 1'b1;
                mem_addr_reg  <= addr_reg + ADDR_ONE;
                rd_pipe_reg   <= 2'b01;
                load_pend_reg <= 1'b1;
              end
            end
            // A falling edge at a word boundary loads the prefetched word instead
            // of shifting; the one before the first data bit leaves the MSB alone.
            if (fall) begin
              if (bit_cnt_reg == '0) begin
                if (load_pend_reg) begin
                  shift_reg     <= buf_reg;
                  load_pend_reg <= 1'b0;
                end
              end else begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          IGNORE: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso    = shift_reg[DATA_WIDTH-1];
  assign spi_miso_oe = busy_reg;
  assign busy        = busy_reg;
  assign mem_en      = mem_en_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Scoreboard bench for spi_ram_bridge: a host task drives SPI frames, a RAM model
// answers the port, and a monitor checks RAM accesses and MISO bytes against queues.
module tb_spi_ram_bridge;

  logic        clk = 1'b0;
  logic        rst, spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe, mem_en, mem_we, busy;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  spi_ram_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  int checks = 0;
  int passes = 0;
  int half_ns = 60;
  logic [7:0]  exp_waddr_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [7:0]  exp_raddr_q[$];
  logic [7:0]  exp_rx_q[$];
  logic [7:0]  rx_q[$];
  bit rd_frame = 1'b0;
  bit miso_bad = 1'b0;
  bit prev_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT accesses the RAM or the host receives a byte
  initial begin
    logic [7:0]  a, r, e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        chk("mem_en_one_cycle", 32'(prev_en), 32'h0);
        if (mem_we) begin
          if (exp_waddr_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", mem_addr, mem_wdata);
          end else begin
            a = exp_waddr_q.pop_front();
            d = exp_wdata_q.pop_front();
            $display("write  addr 0x%02h data 0x%08h", mem_addr, mem_wdata);
            chk("write_addr", 32'(mem_addr), 32'(a));
            chk("write_data", mem_wdata, d);
          end
        end else begin
          if (exp_raddr_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_read: addr 0x%0h, no read expected", mem_addr);
          end else begin
            a = exp_raddr_q.pop_front();
            $display("read   addr 0x%02h", mem_addr);
            chk("read_addr", 32'(mem_addr), 32'(a));
          end
        end
      end
      prev_en = mem_en;
      if (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        if (exp_rx_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_rx: byte 0x%0h, none expected", r);
        end else begin
          e = exp_rx_q.pop_front();
          $display("miso   byte 0x%02h", r);
          chk("miso_byte", 32'(r), 32'(e));
        end
      end
      if (spi_miso && !rd_frame) miso_bad = 1'b1;
    end
  end

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      spi_mosi = tx[b];
      #(half_ns);
      spi_sclk = 1'b1;
      rx = {rx[6:0], spi_miso};
      #(half_ns);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] tx[$], input bit is_read);
    logic [7:0] r;
    @(negedge clk);
    miso_bad = 1'b0;
    rd_frame = is_read;
    spi_cs_n = 1'b0;
    #(half_ns);
    for (int i = 0; i < tx.size(); i++) begin
      spi_byte(tx[i], r);
      if (i == 0) chk("busy_in_frame", 32'({busy, spi_miso_oe}), 32'h3);
      if (is_read && i >= 2) rx_q.push_back(r);
    end
    #(half_ns);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_clear_after_cs", 32'({busy, spi_miso_oe}), 32'h0);
    if (!is_read) chk("miso_quiet", 32'(miso_bad), 32'h0);
    repeat (4) @(posedge clk);
    rd_frame = 1'b0;
  endtask

  task automatic write_frame(input logic [7:0] a, input logic [31:0] words[$]);
    logic [7:0] tx[$];
    logic [7:0] ai;
    tx = {8'h02, a};
    for (int i = 0; i < words.size(); i++) begin
      ai = a + 8'(i);
      for (int k = 3; k >= 0; k--) tx.push_back(words[i][8*k +: 8]);
      exp_waddr_q.push_back(ai);
      exp_wdata_q.push_back(words[i]);
      ref_mem[ai] = words[i];
    end
    frame(tx, 1'b0);
  endtask

  task automatic read_frame(input logic [7:0] a, input int n);
    logic [7:0]  tx[$];
    logic [31:0] w;
    tx = {8'h03, a};
    for (int i = 0; i < n; i++) begin
      w = ref_mem[a + 8'(i)];
      for (int k = 3; k >= 0; k--) begin
        exp_rx_q.push_back(w[8*k +: 8]);
        tx.push_back(8'($urandom));
      end
    end
    // the last word's final rising edge also prefetches the following address
    for (int i = 0; i <= n; i++) exp_raddr_q.push_back(a + 8'(i));
    frame(tx, 1'b1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 800000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  r;
    logic [31:0] words[$];
    rst = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      ram[i] <= ref_mem[i];
    end
    ref_mem[8'h20] = 32'h12345678;
    ref_mem[8'h21] = 32'hCAFEF00D;
    ram[8'h20] <= 32'h12345678;
    ram[8'h21] <= 32'hCAFEF00D;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'({spi_miso, spi_miso_oe, mem_en, mem_we, busy}), 32'h0);
    chk("reset_addr", 32'(mem_addr), 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    write_frame(8'h10, {32'hDEADBEEF});
    write_frame(8'hFF, {32'h11111111, 32'h22222222});
    read_frame(8'h20, 2);
    frame({8'h02, 8'h05, 8'hAA, 8'hBB, 8'hCC}, 1'b0);
    frame({8'hA5, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0);

    // reset in the middle of a write data phase
    @(negedge clk);
    spi_cs_n = 1'b0;
    #(half_ns);
    spi_byte(8'h02, r);
    spi_byte(8'h40, r);
    spi_byte(8'hAA, r);
    for (int b = 0; b < 4; b++) begin
      spi_mosi = 1'b1;
      #(half_ns);
      spi_sclk = 1'b1;
      #(half_ns);
      spi_sclk = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", 32'({spi_miso, spi_miso_oe, mem_en, mem_we, busy}), 32'h0);
    chk("rst_mid_addr", 32'(mem_addr), 32'h0);
    chk("rst_mid_wdata", mem_wdata, 32'h0);
    repeat (3) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    write_frame(8'h01, {32'h00000001});
    read_frame(8'h01, 1);
    read_frame(8'hFF, 2);

    for (int f = 0; f < 10; f++) begin
      int n;
      logic [7:0] a;
      half_ns = 10 * $urandom_range(5, 8);
      a = 8'($urandom);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        words = {};
        for (int i = 0; i < n; i++) words.push_back($urandom);
        write_frame(a, words);
      end else begin
        read_frame(a, n);
      end
    end

    repeat (20) @(posedge clk);
    chk("writes_drained", 32'(exp_waddr_q.size()), 32'h0);
    chk("reads_drained", 32'(exp_raddr_q.size()), 32'h0);
    chk("rx_drained", 32'(exp_rx_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
